// File: rtl/switch_conditioner_pkg.sv
// Shared definitions for the push-button conditioner and the logic
// that consumes its pulses: hold-FSM encoding and default timings.
package switch_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } hold_state_t;

    // 10 ms, 1 s and 200 ms at 25 MHz
    localparam int DEF_DEBOUNCE_CYCLES   = 250000;
    localparam int DEF_LONG_PRESS_CYCLES = 25000000;
    localparam int DEF_REPEAT_CYCLES     = 5000000;

    // Bits needed to count 0..n-1, never less than one
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer followed by a stability counter that only
// lets the level change after DEBOUNCE_CYCLES consistent samples.
module debounce_filter
    import switch_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Level
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_q;
    logic [CW-1:0] cnt;

    // Bring the raw pin into the clock domain
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sync_meta <= i_Switch;
            sync_q    <= sync_meta;
        end
    end

    // Count consecutive disagreeing samples; flip once the run is long enough
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt     <= '0;
            o_Level <= 1'b0;
        end else if (sync_q == o_Level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            o_Level <= ~o_Level;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/switch_conditioner.sv
// Push-button conditioner: debounced level, press/release edges,
// long-press detection and auto-repeat while the button stays held.
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Level,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long,
    output logic o_Repeat
);

    localparam int LW = cnt_width(LONG_PRESS_CYCLES);
    localparam int RW = cnt_width(REPEAT_CYCLES);
    localparam bit REP_EN = (REPEAT_CYCLES > 0);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST =
        RW'(REP_EN ? REPEAT_CYCLES - 1 : 0);

    hold_state_t   state_q;
    hold_state_t   state_d;
    logic          level_q;
    logic [LW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;

    debounce_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_filter (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Switch(i_Switch),
        .o_Level (o_Level)
    );

    // Previous debounced level for edge detection
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            level_q <= 1'b0;
        end else begin
            level_q <= o_Level;
        end
    end

    assign o_Press   = o_Level & ~level_q;
    assign o_Release = ~o_Level & level_q;

    // Hold FSM state register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Hold FSM next state; a release always returns to idle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (o_Press) state_d = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (o_Release)   state_d = ST_IDLE;
                else if (o_Long) state_d = ST_HELD;
            end
            ST_HELD: begin
                if (o_Release) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Hold FSM outputs; release suppresses both timed pulses
    always_comb begin
        o_Long   = 1'b0;
        o_Repeat = 1'b0;
        if (!o_Release) begin
            o_Long   = (state_q == ST_PRESSED) &&
                       (hold_cnt == LONG_LAST);
            o_Repeat = REP_EN && (state_q == ST_HELD) &&
                       (rep_cnt == REP_LAST);
        end
    end

    // Time since press while waiting for the long-press mark
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hold_cnt <= '0;
        end else if (o_Press || o_Release || o_Long) begin
            hold_cnt <= '0;
        end else if (state_q == ST_PRESSED) begin
            hold_cnt <= hold_cnt + LW'(1);
        end
    end

    // Auto-repeat period counter, wraps on each repeat pulse
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rep_cnt <= '0;
        end else if (o_Long || o_Release) begin
            rep_cnt <= '0;
        end else if (state_q == ST_HELD) begin
            if (rep_cnt == REP_LAST) rep_cnt <= '0;
            else                     rep_cnt <= rep_cnt + RW'(1);
        end
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// Randomized and directed bench for switch_conditioner against a
// behavioural model of debounce windows and press age.
module tb_switch_conditioner;

    localparam int D = 4;
    localparam int L = 10;
    localparam int R = 3;

    logic clk;
    logic i_Rst_L;
    logic i_Switch;
    logic o_Level, o_Press, o_Release, o_Long, o_Repeat;
    logic n_Level, n_Press, n_Release, n_Long, n_Repeat;

    int n_vec;
    int n_err;
    int cyc;

    switch_conditioner #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .REPEAT_CYCLES    (R)
    ) dut (
        .i_Clk    (clk),
        .i_Rst_L  (i_Rst_L),
        .i_Switch (i_Switch),
        .o_Level  (o_Level),
        .o_Press  (o_Press),
        .o_Release(o_Release),
        .o_Long   (o_Long),
        .o_Repeat (o_Repeat)
    );

    switch_conditioner #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .REPEAT_CYCLES    (0)
    ) dut_norep (
        .i_Clk    (clk),
        .i_Rst_L  (i_Rst_L),
        .i_Switch (i_Switch),
        .o_Level  (n_Level),
        .o_Press  (n_Press),
        .o_Release(n_Release),
        .o_Long   (n_Long),
        .o_Repeat (n_Repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic m_pipe0, m_pipe1;
    logic m_level, m_prev;
    logic q_seen[$];
    bit   m_pressed;
    int   m_age;
    logic e_press, e_rel, e_long, e_rep;

    task automatic check(input string tag,
                         input logic [4:0] got,
                         input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%b exp=%b",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pipe0   = 1'b0;
        m_pipe1   = 1'b0;
        m_level   = 1'b0;
        m_prev    = 1'b0;
        q_seen.delete();
        m_pressed = 1'b0;
        m_age     = 0;
        e_press   = 1'b0;
        e_rel     = 1'b0;
        e_long    = 1'b0;
        e_rep     = 1'b0;
    endtask

    // Level flips once the last D synchronized samples since the
    // previous flip all disagree with it; timed events follow age.
    task automatic model_edge(input logic sw);
        bit flip;
        q_seen.push_back(m_pipe1);
        if (q_seen.size() > D) void'(q_seen.pop_front());
        flip = (q_seen.size() == D);
        foreach (q_seen[i]) if (q_seen[i] == m_level) flip = 1'b0;
        if (flip) q_seen.delete();
        m_pipe1 = m_pipe0;
        m_pipe0 = sw;
        m_prev  = m_level;
        m_level = flip ? ~m_level : m_level;
        e_press = m_level & ~m_prev;
        e_rel   = ~m_level & m_prev;
        e_long  = 1'b0;
        e_rep   = 1'b0;
        if (e_press) begin
            m_pressed = 1'b1;
            m_age     = 0;
        end else if (e_rel) begin
            m_pressed = 1'b0;
        end else if (m_pressed) begin
            m_age++;
            e_long = (m_age == L);
            e_rep  = (m_age > L) && ((m_age - L) % R == 0);
        end
    endtask

    task automatic step(input logic sw, input logic rst);
        @(negedge clk);
        if (i_Rst_L) model_edge(i_Switch);
        i_Switch = sw;
        i_Rst_L  = rst;
        if (!rst) model_reset();
        #1;
        check("main",
              {o_Level, o_Press, o_Release, o_Long, o_Repeat},
              {m_level, e_press, e_rel, e_long, e_rep});
        check("norep",
              {n_Level, n_Press, n_Release, n_Long, n_Repeat},
              {m_level, e_press, e_rel, e_long, 1'b0});
        cyc++;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        cyc      = 0;
        i_Rst_L  = 1'b0;
        i_Switch = 1'b0;
        model_reset();

        // Switch toggling while held in reset
        for (int i = 0; i < 8; i++) begin
            step(logic'(i % 2), 1'b0);
            check("rst_quiet",
                  {o_Level, o_Press, o_Release, o_Long, o_Repeat},
                  5'b0);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);

        // Glitch of three cycles is filtered out
        for (int i = 0; i < 14; i++) begin
            step(logic'(i < 3), 1'b1);
            check("glitch",
                  {o_Level, o_Press, o_Release, o_Long, o_Repeat},
                  5'b0);
        end

        // Long hold with release landing on a repeat slot
        for (int t = 0; t < 36; t++) begin
            step(logic'(t < 22), 1'b1);
            check("hold_seq",
                  {1'b0, o_Press, o_Release, o_Long, o_Repeat},
                  {1'b0, t == 6, t == 28, t == 16,
                   t == 19 || t == 22 || t == 25});
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);

        // No auto-repeat when the period is zero
        for (int t = 0; t < 48; t++) begin
            step(logic'(t < 40), 1'b1);
            check("norep_seq",
                  {3'b0, n_Long, n_Repeat},
                  {3'b0, t == 16, 1'b0});
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);

        // Reset in the held state with the button still down
        for (int i = 0; i < 22; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0);
            check("rst_held",
                  {o_Level, o_Press, o_Release, o_Long, o_Repeat},
                  5'b0);
        end
        for (int t = 0; t < 14; t++) begin
            step(1'b1, 1'b1);
            check("rst_repress",
                  {3'b0, o_Press, o_Release},
                  {3'b0, t == 6, 1'b0});
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);

        // Random run lengths with occasional reset
        for (int s = 0; s < 60; s++) begin
            logic sw;
            int   len;
            sw  = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 30);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 99) < 2) step(sw, 1'b0);
                else                            step(sw, 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
